// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the memory stage: op codes, FSM states, bypass layout
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mem_state_e;

  localparam int BYP_DATA_W = 32;
  localparam int BYP_IDX_W  = 5;
  localparam int BYP_W      = BYP_DATA_W + BYP_IDX_W + 1;

  function automatic logic is_load(mem_op_e op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] lo);
    return ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && lo[0]) ||
           ((op inside {MEM_LW, MEM_SW}) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response port of the memory stage
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - selects the addressed byte/half of a load word and extends it
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  mem_op_e         op,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (op)
      MEM_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      MEM_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      MEM_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - single-entry memory pipeline stage between execute and writeback
// Optional misaligned-access trap: MEM_MISALIGN_CHECK_EN
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 excp_flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_result,
  input  logic [XLEN-1:0]      in_store_data,
  input  logic [3:0]           in_mem_op,
  input  logic [REG_IDX_W-1:0] in_wreg_idx,
  input  logic                 in_wreg_en,
  mem_stage_if.master          dmem,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_wdata,
  output logic [REG_IDX_W-1:0] out_wreg_idx,
  output logic                 out_wreg_en,
  output logic                 out_excp,
  output logic [XLEN-1:0]      out_badv,
  output logic [BYP_W-1:0]     mem_bypass,
  output logic                 mem_load_busy
);

  mem_state_e           state, state_nxt;
  mem_op_e              op_q;
  mem_op_e              in_op;
  logic [XLEN-1:0]      pc_q, addr_q, sdata_q, wdata_q, align_data;
  logic [REG_IDX_W-1:0] idx_q;
  logic                 wreg_en_q;
  logic                 accept, req_fire, misalign, occupied, byp_en;
  mem_state_e           accept_state;

  assign in_op        = mem_op_e'(in_mem_op);
  assign in_ready     = ~excp_flush & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
  assign accept       = in_valid & in_ready;
  assign accept_state = (is_load(in_op) | is_store(in_op)) ? ST_REQ : ST_DONE;
  assign req_fire     = dmem.dmem_req_valid & dmem.dmem_req_ready;

`ifdef MEM_MISALIGN_CHECK_EN
  logic            excp_q;
  logic [XLEN-1:0] badv_q;

  assign misalign = is_misaligned(op_q, addr_q[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      excp_q <= 1'b0;
      badv_q <= '0;
    end else if (accept) begin
      excp_q <= 1'b0;
      badv_q <= '0;
    end else if ((state == ST_REQ) && !excp_flush && misalign) begin
      excp_q <= 1'b1;
      badv_q <= addr_q;
    end
  end

  assign out_excp = excp_q;
  assign out_badv = badv_q;
`else
  assign misalign = 1'b0;
  assign out_excp = 1'b0;
  assign out_badv = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = accept_state;
      ST_REQ: begin
        if (excp_flush)    state_nxt = ST_IDLE;
        else if (misalign) state_nxt = ST_DONE;
        else if (req_fire) state_nxt = is_store(op_q) ? ST_DONE : ST_WAIT;
      end
      // A flush racing the response needs no drain: the response is consumed now.
      ST_WAIT: begin
        if (dmem.dmem_rsp_valid) state_nxt = excp_flush ? ST_IDLE : ST_DONE;
        else if (excp_flush)     state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        if (excp_flush)     state_nxt = ST_IDLE;
        else if (out_ready) state_nxt = accept ? accept_state : ST_IDLE;
      end
      ST_DRAIN: if (dmem.dmem_rsp_valid) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      wdata_q   <= '0;
      op_q      <= MEM_NONE;
      idx_q     <= '0;
      wreg_en_q <= 1'b0;
    end else if (accept) begin
      pc_q      <= in_pc;
      addr_q    <= in_result;
      sdata_q   <= in_store_data;
      wdata_q   <= in_result;
      op_q      <= in_op;
      idx_q     <= in_wreg_idx;
      wreg_en_q <= in_wreg_en;
    end else if ((state == ST_WAIT) && dmem.dmem_rsp_valid && !excp_flush) begin
      wdata_q   <= align_data;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem.dmem_rdata),
    .addr   (addr_q[1:0]),
    .op     (op_q),
    .result (align_data)
  );

  assign dmem.dmem_req_valid = (state == ST_REQ) & ~excp_flush & ~misalign;
  assign dmem.dmem_we        = is_store(op_q);
  assign dmem.dmem_addr      = {addr_q[XLEN-1:2], 2'b00};

  always_comb begin
    dmem.dmem_wstrb = 4'b0000;
    dmem.dmem_wdata = sdata_q;
    case (op_q)
      MEM_SB: begin
        dmem.dmem_wstrb = 4'b0001 << addr_q[1:0];
        dmem.dmem_wdata = {(XLEN/8){sdata_q[7:0]}};
      end
      MEM_SH: begin
        dmem.dmem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        dmem.dmem_wdata = {(XLEN/16){sdata_q[15:0]}};
      end
      MEM_SW:  dmem.dmem_wstrb = 4'b1111;
      default: dmem.dmem_wstrb = 4'b0000;
    endcase
  end

  assign out_valid    = (state == ST_DONE) & ~excp_flush;
  assign out_pc       = pc_q;
  assign out_wdata    = wdata_q;
  assign out_wreg_idx = idx_q;
  assign out_wreg_en  = wreg_en_q & ~is_store(op_q) & ~out_excp;

  // Load data only becomes forwardable once it has been registered in DONE.
  assign occupied      = (state == ST_REQ) | (state == ST_WAIT) | (state == ST_DONE);
  assign byp_en        = occupied & out_wreg_en & (idx_q != '0) &
                         ~(is_load(op_q) & (state != ST_DONE));
  assign mem_bypass    = {wdata_q, idx_q, byp_en};
  assign mem_load_busy = ((state == ST_REQ) | (state == ST_WAIT)) & is_load(op_q) & wreg_en_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, excp_flush, in_valid, in_ready;
  logic [31:0] in_pc, in_result, in_store_data;
  logic [3:0]  in_mem_op;
  logic [4:0]  in_wreg_idx;
  logic        in_wreg_en;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_wdata, out_badv;
  logic [4:0]  out_wreg_idx;
  logic        out_wreg_en, out_excp;
  logic [37:0] mem_bypass;
  logic        mem_load_busy;
  int          n_checks = 0;
  int          n_fails  = 0;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk(clk), .reset(reset), .excp_flush(excp_flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_result(in_result), .in_store_data(in_store_data), .in_mem_op(in_mem_op),
    .in_wreg_idx(in_wreg_idx), .in_wreg_en(in_wreg_en), .dmem(dmem),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_wdata(out_wdata), .out_wreg_idx(out_wreg_idx), .out_wreg_en(out_wreg_en),
    .out_excp(out_excp), .out_badv(out_badv), .mem_bypass(mem_bypass),
    .mem_load_busy(mem_load_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mem_op_e op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] idx);
    in_valid      = 1'b1;
    in_pc         = res + 32'h100;
    in_result     = res;
    in_store_data = sd;
    in_mem_op     = op;
    in_wreg_idx   = idx;
    in_wreg_en    = 1'b1;
  endtask

  task automatic run_load(input string tag, input mem_op_e op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    dmem.dmem_req_ready = 1'b1;
    out_ready = 1'b1;
    issue(op, addr, 32'h0, 5'd9);
    step();
    in_valid = 1'b0;
    #1;
    check_eq({tag, "_req"}, 64'(dmem.dmem_req_valid), 64'd1);
    check_eq({tag, "_addr"}, 64'(dmem.dmem_addr), 64'({addr[31:2], 2'b00}));
    step();
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = rdata;
    step();
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_wdata"}, 64'(out_wdata), 64'(exp));
    step();
  endtask

  task automatic run_store(input string tag, input mem_op_e op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [3:0] strb,
                           input logic [31:0] wd);
    dmem.dmem_req_ready = 1'b1;
    out_ready = 1'b1;
    issue(op, addr, sd, 5'd3);
    step();
    in_valid = 1'b0;
    #1;
    check_eq({tag, "_req"}, 64'(dmem.dmem_req_valid), 64'd1);
    check_eq({tag, "_we"}, 64'(dmem.dmem_we), 64'd1);
    check_eq({tag, "_strb"}, 64'(dmem.dmem_wstrb), 64'(strb));
    check_eq({tag, "_wdata"}, 64'(dmem.dmem_wdata), 64'(wd));
    step();
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_wen"}, 64'(out_wreg_en), 64'd0);
    step();
  endtask

  initial begin
    reset = 1'b1; excp_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_result = '0; in_store_data = '0; in_mem_op = MEM_NONE;
    in_wreg_idx = '0; in_wreg_en = 1'b0;
    dmem.dmem_req_ready = 1'b0; dmem.dmem_rsp_valid = 1'b0; dmem.dmem_rdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_req_valid", 64'(dmem.dmem_req_valid), 64'd0);
    check_eq("rst_bypass", 64'(mem_bypass), 64'd0);
    check_eq("rst_busy", 64'(mem_load_busy), 64'd0);
    check_eq("rst_excp", 64'(out_excp), 64'd0);
    check_eq("rst_wdata", 64'(out_wdata), 64'd0);
    check_eq("rst_pc", 64'(out_pc), 64'd0);

    // ALU result passes straight through
    out_ready = 1'b1;
    issue(MEM_NONE, 32'h1234, 32'h0, 5'd5);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("add_valid", 64'(out_valid), 64'd1);
    check_eq("add_wdata", 64'(out_wdata), 64'h1234);
    check_eq("add_pc", 64'(out_pc), 64'h1334);
    check_eq("add_bypass", 64'(mem_bypass), 64'({32'h1234, 5'd5, 1'b1}));
    step();
    check_eq("add_idle", 64'(out_valid), 64'd0);

    // LB with a late response
    dmem.dmem_req_ready = 1'b1;
    issue(MEM_LB, 32'h1003, 32'h0, 5'd7);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("lb_req", 64'(dmem.dmem_req_valid), 64'd1);
    check_eq("lb_addr", 64'(dmem.dmem_addr), 64'h1000);
    check_eq("lb_busy_req", 64'(mem_load_busy), 64'd1);
    check_eq("lb_byp_req", 64'(mem_bypass[0]), 64'd0);
    step();
    check_eq("lb_wait_noreq", 64'(dmem.dmem_req_valid), 64'd0);
    check_eq("lb_busy_w1", 64'(mem_load_busy), 64'd1);
    step();
    check_eq("lb_busy_w2", 64'(mem_load_busy), 64'd1);
    check_eq("lb_nvalid_w2", 64'(out_valid), 64'd0);
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata = 32'h80FF_0000;
    step();
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    check_eq("lb_valid", 64'(out_valid), 64'd1);
    check_eq("lb_wdata", 64'(out_wdata), 64'hFFFF_FF80);
    check_eq("lb_busy_done", 64'(mem_load_busy), 64'd0);
    check_eq("lb_bypass", 64'(mem_bypass), 64'({32'hFFFF_FF80, 5'd7, 1'b1}));
    step();

    // SH with back-pressure on the request
    dmem.dmem_req_ready = 1'b0;
    issue(MEM_SH, 32'h2002, 32'h0000_ABCD, 5'd3);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("sh_req_hold", 64'(dmem.dmem_req_valid), 64'd1);
      check_eq("sh_addr", 64'(dmem.dmem_addr), 64'h2000);
      check_eq("sh_strb", 64'(dmem.dmem_wstrb), 64'hC);
      check_eq("sh_wdata", 64'(dmem.dmem_wdata), 64'hABCD_ABCD);
      check_eq("sh_nvalid", 64'(out_valid), 64'd0);
      if (i < 2) step();
    end
    dmem.dmem_req_ready = 1'b1;
    step();
    check_eq("sh_valid", 64'(out_valid), 64'd1);
    check_eq("sh_wen", 64'(out_wreg_en), 64'd0);
    check_eq("sh_byp_en", 64'(mem_bypass[0]), 64'd0);
    step();

    run_load("lh", MEM_LH, 32'h2, 32'h8001_0000, 32'hFFFF_8001);
    run_load("lbu", MEM_LBU, 32'h1, 32'h0000_8000, 32'h0000_0080);
    run_load("lhu", MEM_LHU, 32'h6, 32'hF00D_0000, 32'h0000_F00D);
    run_load("lw", MEM_LW, 32'h40, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_store("sb", MEM_SB, 32'h5, 32'h1234_5677, 4'b0010, 32'h7777_7777);
    run_store("sw", MEM_SW, 32'h8, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // LHU flushed while waiting for data
    issue(MEM_LHU, 32'h10, 32'h0, 5'd4);
    step();
    in_valid = 1'b0;
    step();
    excp_flush = 1'b1;
    #1;
    check_eq("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    excp_flush = 1'b0;
    issue(MEM_NONE, 32'h99, 32'h0, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("drain_in_ready", 64'(in_ready), 64'd0);
      check_eq("drain_nvalid", 64'(out_valid), 64'd0);
      check_eq("drain_noreq", 64'(dmem.dmem_req_valid), 64'd0);
      step();
    end
    in_valid = 1'b0;
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata = 32'h1111_2222;
    #1;
    check_eq("drain_rsp_in_ready", 64'(in_ready), 64'd0);
    step();
    dmem.dmem_rsp_valid = 1'b0;
    #1;
    check_eq("fl_idle_ready", 64'(in_ready), 64'd1);
    check_eq("fl_idle_nvalid", 64'(out_valid), 64'd0);

    // back-to-back ALU ops, then writeback stall
    out_ready = 1'b1;
    issue(MEM_NONE, 32'hA1, 32'h0, 5'd1);
    step();
    issue(MEM_NONE, 32'hB2, 32'h0, 5'd2);
    #1;
    check_eq("b2b_a_wdata", 64'(out_wdata), 64'hA1);
    check_eq("b2b_a_ready", 64'(in_ready), 64'd1);
    step();
    issue(MEM_NONE, 32'hC3, 32'h0, 5'd3);
    #1;
    check_eq("b2b_b_valid", 64'(out_valid), 64'd1);
    check_eq("b2b_b_wdata", 64'(out_wdata), 64'hB2);
    step();
    issue(MEM_NONE, 32'hD4, 32'h0, 5'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_wdata", 64'(out_wdata), 64'hC3);
      check_eq("stall_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("stall_hold_wdata", 64'(out_wdata), 64'hC3);
    step();
    check_eq("b2b_idle", 64'(out_valid), 64'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    dmem.dmem_req_ready = 1'b1;
    issue(MEM_LW, 32'h3, 32'h0, 5'd6);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("mis_noreq", 64'(dmem.dmem_req_valid), 64'd0);
    step();
    check_eq("mis_valid", 64'(out_valid), 64'd1);
    check_eq("mis_excp", 64'(out_excp), 64'd1);
    check_eq("mis_badv", 64'(out_badv), 64'h3);
    check_eq("mis_wen", 64'(out_wreg_en), 64'd0);
    step();
`else
    run_load("lw_unal", MEM_LW, 32'h3, 32'h1122_3344, 32'h1122_3344);
    check_eq("unal_excp", 64'(out_excp), 64'd0);
    check_eq("unal_badv", 64'(out_badv), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage and upstream of writeback.
- Latches one execute-stage result per handshake and performs loads/stores over a valid/ready data-memory port, using the ALU result as the address.
- Aligns and extends load data, then presents the writeback payload plus a register bypass toward execute.
- Holds at most one instruction; supports exception flush, including a flush that arrives while a load is outstanding.

Parameters:
- XLEN, 32, data/address width
- REG_IDX_W, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- excp_flush  in  1  kill held instruction, discard outstanding response
- in_valid  in  1  execute payload valid
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_result  in  XLEN  ALU result (address for memory ops, else writeback data)
- in_store_data  in  XLEN  rs2 value for stores
- in_mem_op  in  4  mem_pkg op code
- in_wreg_idx  in  REG_IDX_W  destination register
- in_wreg_en  in  1  destination write enable
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_rsp_valid  in  1  load data valid (loads only)
- dmem_rdata  in  XLEN  raw word
- out_valid  out  1  writeback payload valid
- out_ready  in  1  writeback accepts
- out_pc  out  XLEN  held PC
- out_wdata  out  XLEN  final register data
- out_wreg_idx  out  REG_IDX_W  destination
- out_wreg_en  out  1  destination write enable
- out_excp  out  1  misaligned-access exception (see Optional Feature)
- out_badv  out  XLEN  faulting address
- mem_bypass  out  38  {data[37:6], idx[5:1], en[0]}
- mem_load_busy  out  1  held load without data yet; hazard unit stalls matching consumers

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset: state=IDLE. Output values: all payload registers 0; out_valid, dmem_req_valid, out_excp, mem_load_busy and mem_bypass all 0; in_ready=1.
- in_ready = ~excp_flush & (IDLE | (DONE & out_ready)).
- Accept on in_valid & in_ready, latching all in_* fields. The next state depends on the latched op:
  - MEM_NONE -> DONE.
  - Load or store -> REQ.
- Latency with zero-wait memory:
  - Non-memory op: out_valid in cycle N+1.
  - Store: completes on request handshake -> out_valid N+2.
  - Load: out_valid the cycle after rsp_valid.
- REQ:
  - dmem_req_valid = ~excp_flush.
  - On req handshake: store -> DONE; load -> WAIT.
  - Outputs are held stable while dmem_req_ready is low.
- WAIT: on rsp_valid, the load_align result is registered into out_wdata -> DONE.
- DONE:
  - out_valid=1.
  - On out_ready: accept a new input (back-to-back, no bubble) or go to IDLE.
- Stores force out_wreg_en=0.
- Load alignment, byte lane = addr[1:0], half lane = addr[1]:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Store encoding:
  - SB: strobe 4'b0001<<addr[1:0], byte replicated x4.
  - SH: strobe 4'b0011<<{addr[1],1'b0}, half replicated x2.
  - SW: strobe 4'b1111.
- Bypass:
  - en=1 when occupied (REQ/WAIT/DONE) & wreg_en & idx!=0 & not a pending load.
  - Load data is bypassed only in DONE.
  - mem_load_busy = load in REQ/WAIT with wreg_en.
- Flush (excp_flush=1):
  - IDLE/REQ/DONE -> IDLE next cycle; payload is dropped.
  - WAIT -> DRAIN.
  - DRAIN: in_ready=0; on rsp_valid, data is discarded -> IDLE.
- Flush has priority over same-cycle in_valid and out_ready.
- A flush in the same cycle as rsp_valid in WAIT -> IDLE directly.
- Reset mid-operation: state -> IDLE unconditionally. The memory subsystem is reset with the same signal, so no drain is needed.

Optional Feature:
- MEM_MISALIGN_CHECK_EN
- Defined:
  - In REQ, a misaligned access (half with addr[0]=1; word with addr[1:0]!=0) issues no request and goes straight to DONE.
  - It sets out_excp=1, out_badv=address, out_wreg_en=0.
- Undefined:
  - out_excp=0, out_badv=0.
  - Word accesses ignore addr[1:0]; half accesses ignore addr[0].

Decomposition:
- mem_pkg: mem op enum (NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8), is_load/is_store helper functions, state enum, bypass field widths.
- One sub-module: load_align (combinational: rdata, addr[1:0], op -> XLEN result).

Test Plan:
- ADD result 0x1234 to x5, out_ready=1 -> out_valid next cycle; wdata 0x1234; bypass {0x1234,5,1}.
- LB addr 0x1003, rdata 0x80FF_0000, rsp 2 cycles late -> mem_load_busy during WAIT; wdata 0xFFFF_FF80.
- SH addr 0x2002, data 0x0000_ABCD, req_ready low 3 cycles -> request held stable; strobe 4'b1100; wdata 0xABCD_ABCD; out_wreg_en=0.
- LHU addr 0x10, then excp_flush in WAIT, rsp arrives 4 cycles later -> in_ready=0 until rsp; no out_valid; then IDLE.
- Back-to-back ALU ops with out_ready=1, then out_ready=0 for 2 cycles -> no bubbles; DONE held; in_ready=0 while stalled.
- MEM_MISALIGN_CHECK_EN: LW addr 0x3 -> no dmem_req_valid; out_excp=1; out_badv=0x3.
